// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues req/ack reads at the current PC and holds the result for decode.
// Optional FETCH_UNIT_STATS_EN macro adds fetch/stall event counters.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] IF_PC,
    output logic              IF_PC_WRITE,
    input  logic              IF_FLUSH,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] IMEM_RDATA,
    output logic [DATA_W-1:0] IF_INSTR,
    output logic [ADDR_W-1:0] IF_INSTR_PC,
    output logic              IF_VALID,
    input  logic              IF_READY,
    output logic              IF_FAULT,
`ifdef FETCH_UNIT_STATS_EN
    output logic [31:0]       IF_FETCH_CNT,
    output logic [31:0]       IF_STALL_CNT,
`endif
    output logic [1:0]        IF_FAULT_CAUSE
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_FAULT} state_t;

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [1:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            cause_q <= 2'b00;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        cause_d = cause_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            S_IDLE: begin
                if (IF_FLUSH) begin
                    state_d = S_IDLE;
                end else if (IF_PC[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                    cause_d = 2'b01;
                end else begin
                    addr_d  = IF_PC;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (IMEM_ACK) begin
                    // A redirect seen during this request makes the returned word stale.
                    if (drop_q || IF_FLUSH) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        instr_d = IMEM_RDATA;
                        ipc_d   = addr_q;
                        state_d = S_OUT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (IF_FLUSH) drop_d = 1'b1;
                    // Once a drop is pending the request must complete, so no timeout.
                    if ((TIMEOUT != 0) && !drop_q && !IF_FLUSH && (cnt_q == CNT_LAST)) begin
                        cnt_d   = '0;
                        cause_d = 2'b10;
                        state_d = S_FAULT;
                    end
                end
            end
            S_OUT: begin
                if (IF_FLUSH || IF_READY) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (IF_FLUSH) begin
                    cause_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IMEM_REQ    = (state_q == S_REQ);
        IF_VALID    = (state_q == S_OUT);
        IF_FAULT    = (state_q == S_FAULT);
        IF_PC_WRITE = RST_N && (IF_FLUSH || ((state_q == S_OUT) && IF_READY));
    end

    assign IMEM_ADDR      = addr_q;
    assign IF_INSTR       = instr_q;
    assign IF_INSTR_PC    = ipc_q;
    assign IF_FAULT_CAUSE = cause_q;

`ifdef FETCH_UNIT_STATS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == S_OUT) && IF_READY && !IF_FLUSH)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (((state_q == S_REQ) && !IMEM_ACK) || ((state_q == S_OUT) && !IF_READY))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign IF_FETCH_CNT = fetch_cnt_q;
    assign IF_STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, backpressure, misalignment, timeout, flush-in-REQ, async reset.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic          flush, ack, ready;
    logic [DW-1:0] rdata;
    logic          pcw, req, vld, fault;
    logic [AW-1:0] addr, ipc;
    logic [DW-1:0] instr;
    logic [1:0]    cause;
`ifdef FETCH_UNIT_STATS_EN
    logic [31:0]   fetch_cnt, stall_cnt;
`endif

    int vecs = 0;
    int errs = 0;
    int pcw_pulses = 0;
    bit dead_seen = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.TIMEOUT(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(clk), .RST_N(rst_n), .IF_PC(pc), .IF_PC_WRITE(pcw), .IF_FLUSH(flush),
        .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_ACK(ack), .IMEM_RDATA(rdata),
        .IF_INSTR(instr), .IF_INSTR_PC(ipc), .IF_VALID(vld), .IF_READY(ready),
        .IF_FAULT(fault),
`ifdef FETCH_UNIT_STATS_EN
        .IF_FETCH_CNT(fetch_cnt), .IF_STALL_CNT(stall_cnt),
`endif
        .IF_FAULT_CAUSE(cause)
    );

    always @(negedge clk) begin
        if (pcw) pcw_pulses++;
        if (vld && instr == 32'hDEADBEEF) dead_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; pc = '0; flush = 1'b1; ack = 1'b0; ready = 1'b0; rdata = '0;
        #12;
        chk("rst_req", req, 0);
        chk("rst_valid", vld, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pcw", pcw, 0);
        chk("rst_addr", addr, 0);
        chk("rst_cause", cause, 0);
        flush = 1'b0; ready = 1'b1;
        rst_n = 1'b1;

        // basic fetch, ack in the second REQ cycle
        tick();
        chk("t1_req", req, 1);
        chk("t1_addr", addr, 32'h0);
        tick();
        chk("t1_req_hold", req, 1);
        ack = 1'b1; rdata = 32'h00000013;
        tick();
        ack = 1'b0;
        chk("t1_valid", vld, 1);
        chk("t1_instr", instr, 32'h13);
        chk("t1_ipc", ipc, 32'h0);
        chk("t1_pcw", pcw, 1);
        tick();
        pc = 32'h4;
        chk("t1_valid_drop", vld, 0);
        chk("t1_pcw_drop", pcw, 0);
        tick();
        chk("t1_req2", req, 1);
        chk("t1_addr2", addr, 32'h4);

        // backpressure
        ack = 1'b1; rdata = 32'hA5A50001; ready = 1'b0;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", vld, 1);
            chk("t2_instr", instr, 32'hA5A50001);
            chk("t2_pcw", pcw, 0);
            tick();
        end
        chk("t2_ipc", ipc, 32'h4);
        ready = 1'b1;
        #1;
        chk("t2_pcw_hs", pcw, 1);
        tick();
        pc = 32'h6;
        chk("t2_valid_drop", vld, 0);

        // misaligned PC
        tick();
        chk("t3_fault", fault, 1);
        chk("t3_cause", cause, 2'b01);
        chk("t3_req", req, 0);
        tick();
        chk("t3_fault_hold", fault, 1);
        chk("t3_req_hold", req, 0);
        flush = 1'b1;
        #1;
        chk("t3_pcw", pcw, 1);
        tick();
        flush = 1'b0; pc = 32'h100;
        chk("t3_fault_clr", fault, 0);
        chk("t3_cause_clr", cause, 0);
        tick();
        chk("t3_req", req, 1);
        chk("t3_addr", addr, 32'h100);
        ack = 1'b1; rdata = 32'h11111111;
        tick();
        ack = 1'b0;
        chk("t3_valid", vld, 1);
        chk("t3_instr", instr, 32'h11111111);
        chk("t3_ipc", ipc, 32'h100);
        tick();
        pc = 32'h104;

        // timeout after four REQ cycles
        tick();
        chk("t4_addr", addr, 32'h104);
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", req, 1);
            tick();
        end
        chk("t4_req_off", req, 0);
        chk("t4_fault", fault, 1);
        chk("t4_cause", cause, 2'b10);
        flush = 1'b1;
        tick();
        flush = 1'b0; pc = 32'h200;
        chk("t4_fault_clr", fault, 0);
        tick();
        chk("t4b_addr", addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            chk("t4b_req", req, 1);
            tick();
        end
        chk("t4b_req4", req, 1);
        ack = 1'b1; rdata = 32'h22222222;
        tick();
        ack = 1'b0;
        chk("t4b_valid", vld, 1);
        chk("t4b_fault", fault, 0);
        chk("t4b_instr", instr, 32'h22222222);
        tick();
        pc = 32'h204;

        // flush during REQ, late ack must be discarded
        tick();
        chk("t5_req1", req, 1);
        base = pcw_pulses;
        tick();
        flush = 1'b1;
        #1;
        chk("t5_pcw", pcw, 1);
        tick();
        flush = 1'b0; pc = 32'h300;
        chk("t5_req3", req, 1);
        tick();
        chk("t5_req4", req, 1);
        chk("t5_fault4", fault, 0);
        tick();
        chk("t5_req5", req, 1);
        ack = 1'b1; rdata = 32'hDEADBEEF;
        tick();
        ack = 1'b0;
        chk("t5_valid", vld, 0);
        chk("t5_req_off", req, 0);
        tick();
        chk("t5_req_new", req, 1);
        chk("t5_addr_new", addr, 32'h300);
        chk("t5_pulses", pcw_pulses - base, 1);
        chk("t5_dead", dead_seen, 0);

        // asynchronous reset mid-REQ
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_req", req, 0);
        chk("t6_valid", vld, 0);
        chk("t6_fault", fault, 0);
        chk("t6_addr", addr, 0);
        pc = 32'h400;
        #10;
        rst_n = 1'b1;
        tick();
        chk("t6_req_new", req, 1);
        chk("t6_addr_new", addr, 32'h400);
        ack = 1'b1; rdata = 32'h00000044;
        tick();
        ack = 1'b0;
        chk("t6_valid_new", vld, 1);
        chk("t6_instr_new", instr, 32'h44);
        chk("t6_ipc_new", ipc, 32'h400);
        tick();
        chk("t6_idle", vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly downstream of the program counter register. Takes the current PC value and issues a req/ack read to instruction memory. Holds the returned instruction for decode under a valid/ready handshake. Pulses the PC write enable so the upstream next-PC mux value is loaded once per consumed instruction or redirect.

Parameters:
TIMEOUT, 255, max REQ cycles without IMEM_ACK before fault; 0 disables timeout
ADDR_W, 32, PC/instruction address width
DATA_W, 32, instruction width

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  reset, asynchronous, active-low
IF_PC  in  ADDR_W  current PC register output
IF_PC_WRITE  out  1  write enable to PC register, one-cycle pulse
IF_FLUSH  in  1  redirect (taken branch/jump/trap); PC mux already selects target
IMEM_REQ  out  1  memory read request
IMEM_ADDR  out  ADDR_W  read address, registered
IMEM_ACK  in  1  memory data valid this cycle
IMEM_RDATA  in  DATA_W  read data, sampled when IMEM_ACK=1
IF_INSTR  out  DATA_W  fetched instruction
IF_INSTR_PC  out  ADDR_W  address of IF_INSTR
IF_VALID  out  1  IF_INSTR valid for decode
IF_READY  in  1  decode accepts when IF_VALID & IF_READY
IF_FAULT  out  1  fetch fault pending
IF_FAULT_CAUSE  out  2  01 misaligned PC, 10 memory timeout, 00 none

Behaviour:
- Clock CLK; reset is asynchronous, active-low on RST_N. RST_N=0 immediately forces state IDLE and all outputs to 0, including counters, drop flag, and registers. Any in-flight request is abandoned.
- States: IDLE, REQ, OUT, FAULT.
- IDLE:
  - If IF_FLUSH=1: pulse IF_PC_WRITE and stay in IDLE.
  - Else if IF_PC[1:0]!=0: go to FAULT with cause 01. No request is issued.
  - Else: capture IF_PC into IMEM_ADDR and go to REQ.
- REQ:
  - IMEM_REQ=1 with IMEM_ADDR stable until IMEM_ACK.
  - The wait counter increments each REQ cycle without ACK.
  - On ACK: latch IMEM_RDATA into IF_INSTR and IMEM_ADDR into IF_INSTR_PC. Go to OUT with IF_VALID=1 the next cycle. Minimum latency from IDLE to IF_VALID is 2 cycles when ACK arrives the same cycle.
  - Counter reaching TIMEOUT without ACK (TIMEOUT!=0): drop IMEM_REQ and go to FAULT with cause 10.
  - ACK in the same cycle the counter hits TIMEOUT: ACK wins.
- OUT:
  - IF_VALID and IF_INSTR are held stable until IF_READY.
  - On handshake: pulse IF_PC_WRITE in that cycle, deassert IF_VALID, go to IDLE. The next fetch uses the updated IF_PC, giving 1 bubble cycle.
- FAULT:
  - IF_FAULT=1 with cause held; IF_VALID=0, IMEM_REQ=0.
  - Exit only on IF_FLUSH: pulse IF_PC_WRITE, clear fault and cause, go to IDLE.
- Flush:
  - IDLE/OUT/FAULT: IF_PC_WRITE pulses in the flush cycle. IF_VALID=0 next cycle; next state IDLE.
  - REQ: IF_PC_WRITE pulses, the drop flag is set, and IMEM_REQ stays high until ACK (handshake never abandoned). On ACK with drop set, data is discarded, the flag is cleared, and the next state is IDLE with no IF_VALID.
  - Flush and handshake in the same OUT cycle: flush wins. Single IF_PC_WRITE pulse, next state IDLE.
- IF_PC_WRITE is never high for 2 consecutive cycles unless IF_FLUSH is held.

Optional Feature:
Macro FETCH_UNIT_STATS_EN.
- Defined: adds outputs IF_FETCH_CNT (32) and IF_STALL_CNT (32).
  - IF_FETCH_CNT increments on each OUT handshake.
  - IF_STALL_CNT increments on each REQ cycle without ACK and each OUT cycle with IF_READY=0.
  - Both wrap at 2^32 and reset to 0 on RST_N.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Basic fetch. Reset release, IF_PC=0x0, ACK one cycle after REQ with RDATA=0x00000013, IF_READY=1 → IF_INSTR=0x13, IF_INSTR_PC=0x0, IF_VALID for 1 cycle, one IF_PC_WRITE pulse. Next IMEM_ADDR is the new IF_PC (e.g. 0x4).
2. Backpressure. IF_READY=0 for 5 cycles in OUT → IF_VALID and IF_INSTR stable, no IF_PC_WRITE until IF_READY=1.
3. Misaligned PC. IF_PC=0x6 → IMEM_REQ never asserts, IF_FAULT=1, cause=01. IF_FLUSH with IF_PC=0x100 → IF_PC_WRITE pulse, then fetch from 0x100.
4. Timeout. TIMEOUT=4, no ACK → IMEM_REQ high 4 cycles, then IF_FAULT=1, cause=10. Separate run: ACK on the 4th cycle → no fault.
5. Flush during REQ. Flush on cycle 2 of REQ, ACK on cycle 5 with 0xDEADBEEF → IF_VALID never asserts for 0xDEADBEEF, exactly one IF_PC_WRITE pulse, then a new fetch.
6. Async reset. RST_N=0 mid-REQ between clock edges → IMEM_REQ, IF_VALID, IF_FAULT go to 0 without a clock edge. After release, fetch restarts from IDLE.
